// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one instruction into ALU op/operands, captures the ALU result and returns it with valid/ready
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_taken,
    output logic              res_illegal
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;
    state_t state, state_n;
    logic [5:0] op_q, fn_q;
    logic [DATA_W-1:0] rs_q, rt_q, se, ze, in2_d;
    logic [IMM_W-1:0] imm_q;
    logic [3:0] op_d;
    logic ill_d, beq_d, bne_d, ill_q, beq_q, bne_q, settle;
    assign se = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    assign ze = {{(DATA_W-IMM_W){1'b0}}, imm_q};
    assign in_ready = (state == IDLE) && !reset;
    assign res_valid = (state == DONE);
    always_comb begin
        op_d = 4'b0000;
        in2_d = '0;
        ill_d = 1'b0;
        beq_d = 1'b0;
        bne_d = 1'b0;
        case (op_q)
            6'h00: begin
                in2_d = rt_q;
                case (fn_q)
                    6'h20: op_d = 4'b0010;
                    6'h22: op_d = 4'b0110;
                    6'h24: op_d = 4'b0000;
                    6'h25: op_d = 4'b0001;
                    6'h2A: op_d = 4'b0111;
                    default: ill_d = 1'b1;
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin op_d = 4'b0010; in2_d = se; end
            6'h0A: begin op_d = 4'b0111; in2_d = se; end
            6'h0C: begin op_d = 4'b0000; in2_d = ze; end
            6'h0D: begin op_d = 4'b0001; in2_d = ze; end
            6'h04: begin op_d = 4'b0110; in2_d = rt_q; beq_d = 1'b1; end
            6'h05: begin op_d = 4'b0110; in2_d = rt_q; bne_d = 1'b1; end
            default: ill_d = 1'b1;
        endcase
    end
    // EXEC takes two cycles: the first lets the registered operands settle through the external ALU
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? DECODE : IDLE;
            DECODE:  state_n = EXEC;
            EXEC:    state_n = settle ? DONE : EXEC;
            default: state_n = res_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            settle <= 1'b0;
            op_q <= '0;
            fn_q <= '0;
            rs_q <= '0;
            rt_q <= '0;
            imm_q <= '0;
            ill_q <= 1'b0;
            beq_q <= 1'b0;
            bne_q <= 1'b0;
            alu_op <= '0;
            alu_in1 <= '0;
            alu_in2 <= '0;
            res_data <= '0;
            res_taken <= 1'b0;
            res_illegal <= 1'b0;
        end else begin
            state <= state_n;
            settle <= (state == EXEC) && !settle;
            if (in_ready && in_valid) begin
                op_q <= opcode;
                fn_q <= funct;
                rs_q <= rs_val;
                rt_q <= rt_val;
                imm_q <= imm;
            end
            if (state == DECODE) begin
                alu_op <= ill_d ? 4'b0000 : op_d;
                alu_in1 <= ill_d ? '0 : rs_q;
                alu_in2 <= ill_d ? '0 : in2_d;
                ill_q <= ill_d;
                beq_q <= beq_d && !ill_d;
                bne_q <= bne_d && !ill_d;
            end
            if (state == EXEC && settle) begin
                res_data <= ill_q ? '0 : alu_out;
                res_taken <= (beq_q && alu_zero) || (bne_q && !alu_zero);
                res_illegal <= ill_q;
            end
        end
    end
endmodule
